// File: rtl/dds_pwm_modulator.sv
// Multi-channel DDS sine PWM modulator: one phase accumulator and carrier,
// per-channel LUT offset and amplitude scale, duty updates only at carrier wrap.
module dds_pwm_modulator #(
    parameter int CH_P    = 3,
    parameter int DEPTH_P = 8,
    parameter int WIDTH_P = 12,
    parameter int ACC_W_P = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    en,
    input  logic [15:0]             presc,
    input  logic [ACC_W_P-1:0]      phase_inc,
    input  logic [CH_P*DEPTH_P-1:0] phase_off,
    input  logic [8:0]              ampl_scale,
    output logic [CH_P-1:0]         pwm_out,
    output logic                    sync_out
);
    localparam int PW = WIDTH_P + 10;
    localparam logic [WIDTH_P-1:0] MID = WIDTH_P'(1) << (WIDTH_P - 1);
    localparam logic [WIDTH_P-1:0] CMAX = '1;

    logic [15:0]             pre_cnt;
    logic [15:0]             presc_sh;
    logic [WIDTH_P-1:0]      carrier;
    logic [ACC_W_P-1:0]      acc;
    logic [ACC_W_P-1:0]      inc_sh;
    logic [CH_P*DEPTH_P-1:0] off_sh;
    logic [8:0]              scale_sh;
    logic [8:0]              scale_clamped;
    logic                    tick;
    logic                    wrap;

    logic [DEPTH_P-1:0]        idx_q  [CH_P];
    logic signed [WIDTH_P:0]   s_q    [CH_P];
    logic [WIDTH_P-1:0]        nxt_q  [CH_P];
    logic [WIDTH_P-1:0]        duty_q [CH_P];
    logic signed [PW-1:0]      prod   [CH_P];
    logic [WIDTH_P-1:0]        shifted [CH_P];

    // Quarter-wave magnitude table, round(2047*sin(2*pi*i/256)), i = 0..64
    function automatic logic [10:0] qtab(input logic [6:0] i);
        logic [10:0] q;
        case (i)
            7'd0:  q = 11'd0;    7'd1:  q = 11'd50;   7'd2:  q = 11'd100;
            7'd3:  q = 11'd151;  7'd4:  q = 11'd201;  7'd5:  q = 11'd251;
            7'd6:  q = 11'd300;  7'd7:  q = 11'd350;  7'd8:  q = 11'd399;
            7'd9:  q = 11'd449;  7'd10: q = 11'd497;  7'd11: q = 11'd546;
            7'd12: q = 11'd594;  7'd13: q = 11'd642;  7'd14: q = 11'd690;
            7'd15: q = 11'd737;  7'd16: q = 11'd783;  7'd17: q = 11'd830;
            7'd18: q = 11'd875;  7'd19: q = 11'd920;  7'd20: q = 11'd965;
            7'd21: q = 11'd1009; 7'd22: q = 11'd1052; 7'd23: q = 11'd1095;
            7'd24: q = 11'd1137; 7'd25: q = 11'd1179; 7'd26: q = 11'd1219;
            7'd27: q = 11'd1259; 7'd28: q = 11'd1299; 7'd29: q = 11'd1337;
            7'd30: q = 11'd1375; 7'd31: q = 11'd1411; 7'd32: q = 11'd1447;
            7'd33: q = 11'd1483; 7'd34: q = 11'd1517; 7'd35: q = 11'd1550;
            7'd36: q = 11'd1582; 7'd37: q = 11'd1614; 7'd38: q = 11'd1644;
            7'd39: q = 11'd1674; 7'd40: q = 11'd1702; 7'd41: q = 11'd1729;
            7'd42: q = 11'd1756; 7'd43: q = 11'd1781; 7'd44: q = 11'd1805;
            7'd45: q = 11'd1828; 7'd46: q = 11'd1850; 7'd47: q = 11'd1871;
            7'd48: q = 11'd1891; 7'd49: q = 11'd1910; 7'd50: q = 11'd1927;
            7'd51: q = 11'd1944; 7'd52: q = 11'd1959; 7'd53: q = 11'd1973;
            7'd54: q = 11'd1986; 7'd55: q = 11'd1997; 7'd56: q = 11'd2008;
            7'd57: q = 11'd2017; 7'd58: q = 11'd2025; 7'd59: q = 11'd2032;
            7'd60: q = 11'd2037; 7'd61: q = 11'd2041; 7'd62: q = 11'd2045;
            7'd63: q = 11'd2046;
            default: q = 11'd2047;
        endcase
        return q;
    endfunction

    // Signed sample LUT[k]-MID, unfolded from the quarter table
    function automatic logic signed [WIDTH_P:0] lut_s(input logic [DEPTH_P-1:0] k);
        logic [6:0]              qi;
        logic signed [WIDTH_P:0] m;
        qi = k[DEPTH_P-2] ? 7'd64 - {1'b0, k[DEPTH_P-3:0]}
                          : {1'b0, k[DEPTH_P-3:0]};
        m = (WIDTH_P+1)'(qtab(qi));
        return k[DEPTH_P-1] ? -m : m;
    endfunction

    assign scale_clamped = (ampl_scale > 9'd256) ? 9'd256 : ampl_scale;
    assign tick = (pre_cnt == presc_sh);
    assign wrap = tick && (carrier == CMAX);

    always_comb begin
        for (int c = 0; c < CH_P; c++) begin
            prod[c] = PW'(s_q[c]) * PW'($signed({1'b0, scale_sh}));
            shifted[c] = WIDTH_P'(prod[c] >>> 8);
        end
    end

    // Pipeline free-runs; its inputs only move at wrap, so it settles in 3 clocks
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int c = 0; c < CH_P; c++) begin
                idx_q[c] <= '0;
                s_q[c]   <= '0;
                nxt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH_P; c++) begin
                idx_q[c] <= acc[ACC_W_P-1 -: DEPTH_P]
                          + off_sh[c*DEPTH_P +: DEPTH_P];
                s_q[c]   <= lut_s(idx_q[c]);
                nxt_q[c] <= MID + shifted[c];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pre_cnt  <= '0;
            carrier  <= '0;
            acc      <= '0;
            presc_sh <= '0;
            inc_sh   <= '0;
            off_sh   <= '0;
            scale_sh <= '0;
            pwm_out  <= '0;
            sync_out <= 1'b0;
            for (int c = 0; c < CH_P; c++) duty_q[c] <= '0;
        end else if (!en) begin
            pre_cnt  <= '0;
            carrier  <= '0;
            pwm_out  <= '0;
            sync_out <= 1'b0;
        end else begin
            pre_cnt  <= tick ? '0 : pre_cnt + 16'd1;
            if (tick) carrier <= carrier + WIDTH_P'(1);
            sync_out <= wrap;
            for (int c = 0; c < CH_P; c++) pwm_out[c] <= (carrier < duty_q[c]);
            if (wrap) begin
                acc      <= acc + inc_sh;
                presc_sh <= presc;
                inc_sh   <= phase_inc;
                off_sh   <= phase_off;
                scale_sh <= scale_clamped;
                for (int c = 0; c < CH_P; c++) duty_q[c] <= nxt_q[c];
            end
        end
    end
endmodule

// File: doc/dds_pwm_modulator.md
Name: dds_pwm_modulator

Overview:
Multi-channel sine PWM modulator and next-generation successor to the single-channel divider-based modulator. Frequency comes from a phase accumulator (DDS) instead of integer clock division. Each channel adds its own phase offset and a shared amplitude scale before driving a per-channel PWM output. Duty values update only at carrier wrap, so outputs are glitch-free. The block sits between the AXI register bank (control inputs) and the board pins (pwm_out).

Parameters:
- CH_P, 3, number of output channels.
- DEPTH_P, 8, log2 of sine LUT entries per signal period.
- WIDTH_P, 12, bits of the amplitude value and of the PWM carrier counter.
- ACC_W_P, 32, phase accumulator width; must be at least DEPTH_P.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, synchronous active-high reset.
- en, input, 1, run enable.
- presc, input, 16, carrier prescaler; the carrier counter advances once every presc+1 clocks.
- phase_inc, input, ACC_W_P, accumulator increment applied per carrier period.
- phase_off, input, CH_P*DEPTH_P, per-channel LUT index offset; channel c uses bits [c*DEPTH_P +: DEPTH_P].
- ampl_scale, input, 9, amplitude scale; 256 = unity, values above 256 are clamped to 256.
- pwm_out, output, CH_P, PWM outputs.
- sync_out, output, 1, one-clock pulse at each carrier wrap.

Behaviour:
- Reset (rst_in=1 at a clock edge), applied the same way mid-operation:
  - pwm_out=0, sync_out=0.
  - Prescaler counter, carrier counter, accumulator, pipeline registers and duty registers all set to 0.
  - Reset has priority over en.
- Prescaler: counts 0..presc; a carrier tick occurs when it equals presc, then it returns to 0.
- Carrier counter: WIDTH_P bits, free-running 0..2^WIDTH_P-1, incremented on each tick.
  - Wrap = tick while carrier = 2^WIDTH_P-1.
  - Carrier period = (presc+1)*2^WIDTH_P clocks.
- presc, phase_inc, phase_off and ampl_scale are shadow-registered at each wrap. Mid-period changes take effect at the next wrap.
- At wrap:
  - acc <= acc + phase_inc_shadow, modulo 2^ACC_W_P.
  - sync_out=1 for that single clock.
- Sine LUT, 2^DEPTH_P entries, unsigned offset-binary:
  - MID = 2^(WIDTH_P-1).
  - LUT[k] = MID + round((MID-1)*sin(2*pi*k/2^DEPTH_P)).
  - Range 1..2^WIDTH_P-1.
- Duty pipeline, 3 registered stages starting the clock after wrap:
  - S1: idx_c = (acc[ACC_W_P-1 -: DEPTH_P] + off_c) mod 2^DEPTH_P.
  - S2: s_c = LUT[idx_c] - MID, signed.
  - S3: next_duty_c = MID + ((s_c * scale) >>> 8), using arithmetic shift (floor); result always lies within 1..2^WIDTH_P-1.
- next_duty_c loads into duty_c at the following wrap, so output lags the accumulator update by one carrier period. The pipeline latency of 3 clocks is always below the minimum carrier period of 2^WIDTH_P clocks.
- Output: pwm_out[c] is registered and equals (carrier < duty_c), evaluated every clock.
  - duty 0 gives constant low.
  - Maximum duty 4095 (WIDTH_P=12) gives high for 4095 of 4096 counts.
- en=0:
  - The next clock forces pwm_out=0 and sync_out=0.
  - Prescaler and carrier clear to 0.
  - Accumulator and duty registers hold their values.
- en 0->1: the carrier restarts from 0 using the held duty registers.
- All channels share one accumulator and one carrier, so channels are phase-coherent and edge-aligned.
- Arithmetic width rule: the product s_c*scale is computed signed at WIDTH_P+10 bits, with no overflow.

Test Plan:
1. Reset mid-run: en=1, presc=0, run 3 periods, then pulse rst_in for 1 clock -> next clock pwm_out=0, sync_out=0; the first period after reset is all-low (duty=0).
2. Midscale: phase_inc=0, phase_off=0, ampl_scale=256, presc=0 -> from the second period on, each pwm_out is high 2048 of every 4096 clocks; sync_out pulses every 4096 clocks.
3. Frequency step: phase_inc=2^24 (one LUT step per period) -> index advances 1 per period. When ch0 idx reaches 64, that period's duty = 4095 (high 4095 clocks). At idx=192, duty = 1.
4. Phase offsets: phase_inc=0, offsets ch0=0, ch1=64, ch2=128 -> duties 2048, 4095, 2048, all rising together at carrier=0.
5. Scaling: at idx 64 with ampl_scale=128 -> duty 3071; with ampl_scale=0 -> 2048; at idx 192 with ampl_scale=128 -> 1024; ampl_scale=300 -> clamped, same result as 256.
6. Prescale/enable: presc=3 -> sync_out period 16384 clocks. Change phase_off mid-period -> duty unchanged until two wraps later. Drop en -> pwm_out=0 next clock; re-raise en -> carrier restarts at 0.
